// File: rtl/axis_pulse_encoder_if.sv
// Stream and config/status bundle for the pulse encoder.
// The DUT uses the slave modport; the stimulus side uses master.
interface axis_pulse_encoder_if;
    logic [31:0] cfg_data;
    logic [31:0] sts_data;
    logic        s_axis_tready;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        m_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;

    modport slave (
        input  cfg_data, s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output sts_data, s_axis_tready, m_axis_tdata, m_axis_tvalid
    );

    modport master (
        output cfg_data, s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  sts_data, s_axis_tready, m_axis_tdata, m_axis_tvalid
    );
endinterface

// File: rtl/axis_pulse_encoder.sv
// Re-encodes a sparse 16-bit sample stream into 64-bit {gap, 0, sample} pulse descriptors,
// with a single-entry output register and a saturating count of dropped descriptors.
module axis_pulse_encoder (
    input  logic                        aclk,
    input  logic                        aresetn,
    axis_pulse_encoder_if.slave         bus
);
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned CNTR_W   = 32;
    localparam int unsigned DESC_W   = 64;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t                state_q,     state_d;
    logic [CNTR_W-1:0]     cntr_q,      cntr_d;
    logic [SAMPLE_W-1:0]   held_q,      held_d;
    logic                  out_valid_q, out_valid_d;
    logic [DESC_W-1:0]     out_data_q,  out_data_d;
    logic [CNTR_W-1:0]     drop_q,      drop_d;

    logic                  emit_c;
    logic                  out_free_c;
    logic [DESC_W-1:0]     emit_data_c;

    // Next-state: sample capture, gap counting, timeout, and output-register load/drop.
    always_comb begin
        state_d     = state_q;
        cntr_d      = cntr_q;
        held_d      = held_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        drop_d      = drop_q;
        emit_c      = 1'b0;
        emit_data_c = {cntr_q, SAMPLE_W'(0), held_q};
        out_free_c  = !out_valid_q || bus.m_axis_tready;

        unique case (state_q)
            ST_EMPTY: begin
                if (bus.s_axis_tvalid) begin
                    held_d  = bus.s_axis_tdata;
                    cntr_d  = CNTR_W'(0);
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.s_axis_tvalid) begin
                    emit_c = 1'b1;
                    held_d = bus.s_axis_tdata;
                    cntr_d = CNTR_W'(0);
                end else if (cntr_q >= bus.cfg_data) begin
                    // Counter never passes cfg_data, so the increment below cannot wrap.
                    emit_c  = 1'b1;
                    cntr_d  = CNTR_W'(0);
                    state_d = ST_EMPTY;
                end else begin
                    cntr_d = cntr_q + CNTR_W'(1);
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (out_free_c) begin
            out_valid_d = emit_c;
            if (emit_c) begin
                out_data_d = emit_data_c;
            end
        end else if (emit_c && (drop_q != {CNTR_W{1'b1}})) begin
            drop_d = drop_q + CNTR_W'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_EMPTY;
            cntr_q      <= CNTR_W'(0);
            held_q      <= SAMPLE_W'(0);
            out_valid_q <= 1'b0;
            out_data_q  <= DESC_W'(0);
            drop_q      <= CNTR_W'(0);
        end else begin
            state_q     <= state_d;
            cntr_q      <= cntr_d;
            held_q      <= held_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.s_axis_tready = 1'b1;
    assign bus.m_axis_tvalid = out_valid_q;
    assign bus.m_axis_tdata  = out_data_q;
    assign bus.sts_data      = drop_q;
endmodule
